imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 86 ++++++++
 tb/tb_imem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   start, load_len            begin a load of load_len words (clamped to DEPTH), accepted only when idle
//   byte_valid, byte_data      incoming byte stream, accepted when byte_ready is high
//   byte_ready                 high while loading
//   imem_wr_en/addr/data       one-cycle write strobe, word address and assembled word
//   busy, cpu_hold             high while a load is in progress
//   done                       one-cycle pulse when a load completes
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_wr_en,
  output logic [31:0]   imem_wr_addr,
  output logic [31:0]   imem_wr_data,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t state, state_n;
  logic [AW:0] words_left, len_clamped;
  logic [AW-1:0] word_idx;
  logic [1:0] byte_cnt;
  logic [23:0] partial;
  logic accept, word_done, last_word;
  assign len_clamped = load_len > DEPTH_W ? DEPTH_W : load_len;
  // byte_ready is high exactly when the registered state is LOAD
  assign accept = byte_ready && byte_valid;
  assign word_done = accept && byte_cnt == 2'd3;
  assign last_word = word_done && words_left == (AW+1)'(1);
  assign cpu_hold = busy;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = len_clamped == '0 ? DONE : LOAD;
    else if (state == LOAD && last_word) state_n = FLUSH;
    else if (state == FLUSH) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      words_left   <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      partial      <= '0;
    end else begin
      state      <= state_n;
      byte_ready <= state_n == LOAD;
      busy       <= state_n == LOAD || state_n == FLUSH;
      done       <= state_n == DONE;
      imem_wr_en <= word_done;
      if (state == IDLE && start) begin
        words_left <= len_clamped;
        word_idx   <= '0;
        byte_cnt   <= '0;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        // shift in from the top so the first byte ends up in bits [7:0]
        partial  <= {byte_data, partial[23:8]};
      end
      if (word_done) begin
        imem_wr_data <= {byte_data, partial};
        imem_wr_addr <= 32'(word_idx);
        word_idx     <= word_idx + 1'b1;
        words_left   <= words_left - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a word-level reference model
module tb_imem_loader;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [AW:0] load_len = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, imem_wr_en, busy, cpu_hold, done;
  logic [31:0] imem_wr_addr, imem_wr_data;
  typedef struct { int n; int addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [7:0] stream [1024];
  logic [31:0] last_addr = 0, last_data = 0;
  int n = 0, strobes = 0, checks = 0, errors = 0;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_flags(input string tag, input logic r, input logic b, input logic d);
    check({tag, "_ready"}, 32'(byte_ready), 32'(r));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  // advance to the next falling edge and score any write strobe against the model
  task automatic step();
    wr_t e;
    @(negedge clk);
    n++;
    if (imem_wr_en) begin
      strobes++;
      if (exp_q.size() == 0) check("spurious_wr", 32'(imem_wr_en), 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_wr_addr, e.addr);
        check("wr_data", imem_wr_data, e.data);
        check("wr_latency", n, e.n);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      check("hold_addr", imem_wr_addr, last_addr);
      check("hold_data", imem_wr_data, last_data);
    end
  endtask

  task automatic do_load(input int len, input int gap_pct, input bit poke_start);
    int words, total, i, s0;
    words = len > DEPTH ? DEPTH : len;
    total = 4 * words;
    i = 0;
    step();
    start = 1;
    load_len = (AW+1)'(len);
    byte_valid = 0;
    step();
    start = 0;
    s0 = strobes;
    if (words == 0) begin
      check_flags("len0_done", 0, 0, 1);
      step();
      check_flags("len0_after", 0, 0, 0);
      step();
      check("len0_strobes", strobes - s0, 0);
      return;
    end
    while (i < total) begin
      check_flags("load", 1, 1, 0);
      start = poke_start && $urandom_range(7) == 0;
      if ($urandom_range(99) < gap_pct) begin
        byte_valid = 0;
        byte_data = 8'($urandom);
      end else begin
        byte_valid = 1;
        byte_data = stream[i];
        if (i % 4 == 3)
          exp_q.push_back('{n + 1, i / 4, {stream[i], stream[i-1], stream[i-2], stream[i-3]}});
        i++;
      end
      step();
    end
    start = 0;
    byte_valid = 1;
    byte_data = 8'($urandom);
    check_flags("flush", 0, 1, 0);
    step();
    check_flags("done", 0, 0, 1);
    step();
    check_flags("idle", 0, 0, 0);
    byte_valid = 0;
    step();
    check("words_written", strobes - s0, words);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic fill_random(input int count);
    for (int k = 0; k < count; k++) stream[k] = 8'($urandom);
  endtask

  initial begin
    #1;
    check_flags("reset", 0, 0, 0);
    check("reset_wr_en", 32'(imem_wr_en), 0);
    check("reset_addr", imem_wr_addr, 0);
    check("reset_data", imem_wr_data, 0);
    @(negedge clk);
    reset = 0;
    // two fixed RISC-V words sent back to back
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h50; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h00; stream[6] = 8'h10; stream[7] = 8'h00;
    do_load(2, 0, 0);
    check("fixed_last_data", last_data, 32'h00100093);
    do_load(0, 0, 0);
    fill_random(1024);
    do_load(300, 0, 0);
    check("clamp_last_addr", last_addr, 255);
    fill_random(12);
    do_load(3, 0, 0);
    do_load(3, 40, 1);
    for (int t = 0; t < 6; t++) begin
      fill_random(64);
      do_load(int'($urandom_range(16)), int'($urandom_range(50)), 1);
    end
    // reset partway through the second word of a 4-word load
    fill_random(16);
    step();
    start = 1;
    load_len = 4;
    step();
    start = 0;
    for (int k = 0; k < 6; k++) begin
      byte_valid = 1;
      byte_data = stream[k];
      if (k == 3) exp_q.push_back('{n + 1, 0, {stream[3], stream[2], stream[1], stream[0]}});
      step();
    end
    byte_valid = 0;
    #2 reset = 1;
    #1;
    check_flags("async_reset", 0, 0, 0);
    check("async_reset_wr_en", 32'(imem_wr_en), 0);
    check("async_reset_addr", imem_wr_addr, 0);
    check("async_reset_data", imem_wr_data, 0);
    last_addr = 0;
    last_data = 0;
    step();
    reset = 0;
    step();
    check("reset_queue", exp_q.size(), 0);
    stream[0] = 8'hef; stream[1] = 8'hbe; stream[2] = 8'had; stream[3] = 8'hde;
    do_load(1, 20, 0);
    check("post_reset_addr", last_addr, 0);
    check("post_reset_data", last_data, 32'hdeadbeef);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
